neuron_input_encoder: RTL and testbench

Rate-coding spike source that drives the `x` input vector of the LIF neuron datapath. Holds one 8-bit intensity per input channel and runs a fixed-length encoding frame. During the frame, each channel emits spikes through a phase accumulator at a rate of intensity/256 per timestep. It shares `clk`, `rst_n` and `ce` with the neuron, so each `ce` step produces one `x` vector for the neuron to integrate.

---
 rtl/neuron_input_encoder.sv | 105 ++++++++++
 tb/tb_neuron_input_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_input_encoder.sv
// neuron_input_encoder: rate-coding spike source feeding the x vector of the LIF neuron.
// Each channel adds its intensity into a phase accumulator on every ce step; the carry-out is the spike.
module neuron_input_encoder #(
    parameter int n_stage = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     wr_en,
    input  logic [n_stage-1:0]       wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    input  logic [7:0]               frame_len,
    output logic [(1<<n_stage)-1:0]  x,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int n_ch = 1 << n_stage;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  shadow [n_ch];
    logic [7:0]  active [n_ch];
    logic [7:0]  acc    [n_ch];
    logic [8:0]  sum    [n_ch];
    logic [7:0]  cnt;
    logic        accept;
    logic        step;
    logic        last_step;

    assign accept    = (state == IDLE) && start && (frame_len != 8'd0);
    assign step      = (state == RUN) && ce;
    assign last_step = step && (cnt == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = RUN;
            RUN:  if (last_step) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_comb begin
        for (int i = 0; i < n_ch; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, active[i]};
        end
    end

    // Shadow bank is writable at any time; active only snapshots it when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_ch; i++) begin
                shadow[i] <= 8'd0;
            end
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_ch; i++) begin
                active[i] <= 8'd0;
                acc[i]    <= 8'd0;
            end
            cnt        <= 8'd0;
            x          <= '0;
            frame_done <= 1'b0;
        end else begin
            x          <= '0;
            frame_done <= 1'b0;
            if (accept) begin
                for (int i = 0; i < n_ch; i++) begin
                    active[i] <= shadow[i];
                    acc[i]    <= 8'd0;
                end
                cnt <= frame_len;
            end else if (step) begin
                for (int i = 0; i < n_ch; i++) begin
                    acc[i] <= sum[i][7:0];
                    x[i]   <= sum[i][8];
                end
                cnt        <= cnt - 8'd1;
                frame_done <= (cnt == 8'd1);
            end
        end
    end

endmodule

// File: tb/tb_neuron_input_encoder.sv
// tb_neuron_input_encoder: directed checks of the rate-coding encoder.
// Inputs change 1 ns after each rising edge, so outputs are sampled well away from the edge.
module tb_neuron_input_encoder;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic [7:0]  frame_len;
    logic [15:0] x;
    logic        busy;
    logic        frame_done;

    int compare_count = 0;
    int fail_count    = 0;
    int spikes [16];
    int total;

    neuron_input_encoder #(.n_stage(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .frame_len  (frame_len),
        .x          (x),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Set all inputs, then advance to 1 ns past the next rising edge.
    task automatic apply_stimulus(input logic st, input logic [7:0] len, input logic c,
                                  input logic we, input logic [3:0] wa, input logic [7:0] wd);
        start     = st;
        frame_len = len;
        ce        = c;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, " x"}, 32'(x), 32'h0);
        check_output({tag, " busy"}, 32'(busy), 32'h0);
        check_output({tag, " frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0; frame_len = 8'd0; ce = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        #2 rst_n = 1'b0;
        #1 check_idle("reset");
        #5 rst_n = 1'b1;

        // I=128 on ch0, L=4, ce continuous
        apply_stimulus(0, 0, 1, 1, 4'd0, 8'd128);
        apply_stimulus(1, 8'd4, 1, 0, 0, 0);
        check_output("t1 busy after start", 32'(busy), 32'h1);
        check_output("t1 x after start", 32'(x), 32'h0);
        for (int s = 1; s <= 4; s++) begin
            apply_stimulus(0, 8'd4, 1, 0, 0, 0);
            check_output($sformatf("t1 x step %0d", s), 32'(x), (s % 2 == 0) ? 32'h1 : 32'h0);
            check_output($sformatf("t1 frame_done step %0d", s), 32'(frame_done), (s == 4) ? 32'h1 : 32'h0);
            check_output($sformatf("t1 busy step %0d", s), 32'(busy), (s < 4) ? 32'h1 : 32'h0);
        end
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_idle("t1 after frame");

        // I=64 on ch3, I=255 on ch5, L=8; then back-to-back frame in the done clock
        apply_stimulus(0, 0, 1, 1, 4'd0, 8'd0);
        apply_stimulus(0, 0, 1, 1, 4'd3, 8'd64);
        apply_stimulus(0, 0, 1, 1, 4'd5, 8'd255);
        apply_stimulus(1, 8'd8, 1, 0, 0, 0);
        for (int s = 1; s <= 8; s++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0);
            check_output($sformatf("t2 x step %0d", s), 32'(x),
                         ((s >= 2) ? 32'h20 : 32'h0) | ((s == 4 || s == 8) ? 32'h08 : 32'h0));
            check_output($sformatf("t2 frame_done step %0d", s), 32'(frame_done), (s == 8) ? 32'h1 : 32'h0);
        end
        apply_stimulus(1, 8'd1, 1, 0, 0, 0);
        check_output("t2 gap busy", 32'(busy), 32'h1);
        check_output("t2 gap x", 32'(x), 32'h0);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_output("t2 L1 x", 32'(x), 32'h0);
        check_output("t2 L1 frame_done", 32'(frame_done), 32'h1);
        check_output("t2 L1 busy", 32'(busy), 32'h0);

        // All channels 255: L=0 ignored, L=255 gives 254 spikes each
        for (int ch = 0; ch < 16; ch++) apply_stimulus(0, 0, 1, 1, 4'(ch), 8'd255);
        apply_stimulus(1, 8'd0, 1, 0, 0, 0);
        check_output("t3 L0 busy", 32'(busy), 32'h0);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_output("t3 L0 busy later", 32'(busy), 32'h0);
        check_output("t3 L0 frame_done", 32'(frame_done), 32'h0);
        apply_stimulus(1, 8'd255, 1, 0, 0, 0);
        for (int ch = 0; ch < 16; ch++) spikes[ch] = 0;
        for (int s = 1; s <= 255; s++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0);
            for (int ch = 0; ch < 16; ch++) spikes[ch] += int'(x[ch]);
            if (s == 255) check_output("t3 frame_done step 255", 32'(frame_done), 32'h1);
        end
        for (int ch = 0; ch < 16; ch++)
            check_output($sformatf("t3 spikes ch%0d", ch), 32'(spikes[ch]), 32'd254);
        for (int ch = 0; ch < 16; ch++) apply_stimulus(0, 0, 1, 1, 4'(ch), 8'd0);
        apply_stimulus(1, 8'd255, 1, 0, 0, 0);
        total = 0;
        for (int s = 1; s <= 255; s++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0);
            total += $countones(x);
        end
        check_output("t3 zero intensity spikes", 32'(total), 32'd0);
        check_output("t3 zero intensity frame_done", 32'(frame_done), 32'h1);

        // ce toggling, I=128, L=4: steps on every other clock
        apply_stimulus(0, 0, 1, 1, 4'd0, 8'd128);
        apply_stimulus(1, 8'd4, 1, 0, 0, 0);
        total = 0;
        for (int j = 1; j <= 8; j++) begin
            apply_stimulus(0, 0, (j % 2 == 0), 0, 0, 0);
            total += $countones(x);
            check_output($sformatf("t4 x clk %0d", j), 32'(x), (j == 4 || j == 8) ? 32'h1 : 32'h0);
            check_output($sformatf("t4 frame_done clk %0d", j), 32'(frame_done), (j == 8) ? 32'h1 : 32'h0);
            check_output($sformatf("t4 busy clk %0d", j), 32'(busy), (j < 8) ? 32'h1 : 32'h0);
        end
        check_output("t4 total spikes", 32'(total), 32'd2);

        // Write and start during RUN affect only the next frame
        apply_stimulus(0, 0, 1, 1, 4'd0, 8'd0);
        apply_stimulus(1, 8'd4, 1, 0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            if (s == 2) apply_stimulus(1, 8'd4, 1, 1, 4'd0, 8'd255);
            else        apply_stimulus(0, 8'd4, 1, 0, 0, 0);
            check_output($sformatf("t5 x step %0d", s), 32'(x), 32'h0);
            check_output($sformatf("t5 frame_done step %0d", s), 32'(frame_done), (s == 4) ? 32'h1 : 32'h0);
        end
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_idle("t5 not restarted");
        apply_stimulus(1, 8'd4, 1, 0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0);
            check_output($sformatf("t5 next x step %0d", s), 32'(x), (s >= 2) ? 32'h1 : 32'h0);
        end
        check_output("t5 next frame_done", 32'(frame_done), 32'h1);

        // Reset mid-frame after 3 of 8 steps (ch0 and ch2 at 255)
        apply_stimulus(0, 0, 1, 1, 4'd2, 8'd255);
        apply_stimulus(1, 8'd8, 1, 0, 0, 0);
        for (int s = 1; s <= 3; s++) apply_stimulus(0, 0, 1, 0, 0, 0);
        check_output("t6 x before reset", 32'(x), 32'h5);
        check_output("t6 busy before reset", 32'(busy), 32'h1);
        #3 rst_n = 1'b0;
        #1 check_idle("t6 during reset");
        #2 rst_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0);
            check_output($sformatf("t6 no frame_done clk %0d", j), 32'(frame_done), 32'h0);
            check_output($sformatf("t6 busy clk %0d", j), 32'(busy), 32'h0);
        end
        apply_stimulus(1, 8'd4, 1, 0, 0, 0);
        check_output("t6 restart busy", 32'(busy), 32'h1);
        for (int s = 1; s <= 4; s++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0);
            check_output($sformatf("t6 restart x step %0d", s), 32'(x), 32'h0);
        end
        check_output("t6 restart frame_done", 32'(frame_done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
